// File: rtl/boa_peri_pwm_multi.sv
// Multi-channel PWM peripheral: shared prescaled timebase, buffered period/duty, wrap interrupt.
// Define BOA_PWM_CENTER_EN to build in center-aligned (up/down) counting.
module boa_peri_pwm_multi #(
    parameter logic [11:0] ADDR     = 12'h400,
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_req,
    input  logic                bus_we,
    input  logic [11:0]         bus_addr,
    input  logic [3:0]          bus_be,
    input  logic [31:0]         bus_wdata,
    output logic                bus_ack,
    output logic [31:0]         bus_rdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                irq
);
    localparam logic [11:0] SPAN = 12'(16 + 4 * CHANNELS);
    localparam int          PAD  = 32 - WIDTH;

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    logic             ctrl_en, ctrl_irq_en;
    logic [7:0]       prescale, presc_cnt;
    logic             wrap;
    logic [WIDTH-1:0] period_buf, active_period, count, count_nxt;
    logic [WIDTH-1:0] duty_buf    [CHANNELS];
    logic [WIDTH-1:0] active_duty [CHANNELS];
    logic             ctrl_center, ctrl_center_nxt, active_center, dir_down, dir_nxt;
    logic             tick, boundary, reload;
    logic [11:0]      offset;
    logic [9:0]       word;
    logic             hit, wr, rd, ctrl_wr;
    logic [31:0]      rd_val;
    logic             unused;

    assign offset  = bus_addr - ADDR;
    assign word    = offset[11:2];
    assign hit     = bus_req && (bus_addr >= ADDR) && (offset < SPAN);
    assign bus_ack = hit;
    assign wr      = hit && bus_we;
    assign rd      = hit && !bus_we;
    assign ctrl_wr = wr && (word == 10'd0);
    assign tick    = ctrl_en && (presc_cnt == 8'd0);
    assign reload  = !ctrl_en || boundary;

`ifdef BOA_PWM_CENTER_EN
    assign ctrl_center_nxt = (ctrl_wr && bus_be[0]) ? bus_wdata[1] : ctrl_center;
    assign unused          = ^offset[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_center   <= 1'b0;
            active_center <= 1'b0;
            dir_down      <= 1'b0;
        end else begin
            ctrl_center <= ctrl_center_nxt;
            if (reload) active_center <= ctrl_center_nxt;
            dir_down <= dir_nxt;
        end
    end
`else
    assign ctrl_center_nxt = 1'b0;
    assign ctrl_center     = 1'b0;
    assign active_center   = 1'b0;
    assign dir_down        = 1'b0;
    assign unused          = ^{offset[1:0], dir_nxt};
`endif

    // Timebase: boundary is the end of an edge frame or the bottom of a center frame
    always_comb begin
        boundary  = 1'b0;
        count_nxt = count;
        dir_nxt   = dir_down;
        if (!ctrl_en) begin
            count_nxt = '0;
            dir_nxt   = 1'b0;
        end else if (tick) begin
            if (active_center) begin
                if (!dir_down) begin
                    if (count >= active_period) begin
                        if (active_period == '0) begin
                            boundary  = 1'b1;
                            count_nxt = '0;
                        end else begin
                            dir_nxt   = 1'b1;
                            count_nxt = count - WIDTH'(1);
                        end
                    end else begin
                        count_nxt = count + WIDTH'(1);
                    end
                end else if (count == '0) begin
                    boundary  = 1'b1;
                    dir_nxt   = 1'b0;
                    count_nxt = (ctrl_center_nxt && period_buf != '0) ? WIDTH'(1) : '0;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end else if (count >= active_period) begin
                boundary  = 1'b1;
                count_nxt = '0;
            end else begin
                count_nxt = count + WIDTH'(1);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (word)
            10'd0:   rd_val = {16'b0, prescale, 5'b0, ctrl_irq_en, ctrl_center, ctrl_en};
            10'd1:   rd_val = {31'b0, wrap};
            10'd2:   rd_val = {{PAD{1'b0}}, period_buf};
            10'd3:   rd_val = {{PAD{1'b0}}, count};
            default: begin
                for (int i = 0; i < CHANNELS; i++)
                    if (word == 10'(4 + i)) rd_val = {{PAD{1'b0}}, duty_buf[i]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en       <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            prescale      <= '0;
            presc_cnt     <= '0;
            wrap          <= 1'b0;
            period_buf    <= '0;
            active_period <= '0;
            count         <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_buf[i]    <= '0;
                active_duty[i] <= '0;
            end
            bus_rdata <= '0;
            pwm_out   <= '0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr && bus_be[0]) begin
                ctrl_en     <= bus_wdata[0];
                ctrl_irq_en <= bus_wdata[2];
            end
            if (ctrl_wr && bus_be[1]) prescale <= bus_wdata[15:8];
            if (wr && word == 10'd2)
                period_buf <= WIDTH'(merge_be({{PAD{1'b0}}, period_buf}, bus_wdata, bus_be));
            for (int i = 0; i < CHANNELS; i++)
                if (wr && word == 10'(4 + i))
                    duty_buf[i] <= WIDTH'(merge_be({{PAD{1'b0}}, duty_buf[i]}, bus_wdata, bus_be));
            // A boundary in the same cycle as a clear keeps WRAP set
            if (boundary)
                wrap <= 1'b1;
            else if (wr && word == 10'd1 && bus_be[0] && bus_wdata[0])
                wrap <= 1'b0;
            if (reload) begin
                active_period <= period_buf;
                for (int i = 0; i < CHANNELS; i++) active_duty[i] <= duty_buf[i];
            end
            count     <= count_nxt;
            presc_cnt <= (!ctrl_en || tick) ? prescale : presc_cnt - 8'd1;
            bus_rdata <= rd ? rd_val : 32'd0;
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= ctrl_en && (count < active_duty[i]);
            irq <= wrap && ctrl_irq_en;
        end
    end
endmodule

// File: doc/boa_peri_pwm_multi.md
# boa_peri_pwm_multi

Multi-channel PWM peripheral on the 12-bit peripheral bus (`boa_mem_bus#(12)`), replacing the practice of instantiating one single-channel PWM per output. It provides a shared timebase with prescaler, one period and N duty registers. Period and duty are double-buffered and reload at the period boundary. A wrap interrupt is provided. Outputs typically drive GPIO external-signal inputs.

## Interface
- `addr`, default `'h400`: base address on the peripheral bus; 4-byte aligned.
- `channels`, default 4: number of PWM outputs, 1–8.
- `width`, default 16: counter, period and duty width, 8–16.
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bus`, `boa_mem_bus.MEM`, 12-bit address: register access.
- `pwm_out`, output, `channels`: PWM outputs; registered.
- `irq`, output, 1: level interrupt, equal to `WRAP && IRQ_EN`; registered.

## Operation
- **Register map** (word offsets from `addr`; unused bits read 0):
  - 0x00 `CTRL` (RW): bit0 `EN`, bit1 `CENTER`, bit2 `IRQ_EN`, bits[15:8] `PRESCALE`.
  - 0x04 `STATUS`: bit0 `WRAP`, sticky; writing 1 clears it.
  - 0x08 `PERIOD`: buffered; reads return the buffer.
  - 0x0C `COUNT`: read-only; writes are ignored.
  - 0x10 + 4·i `DUTY[i]` for i < `channels`: buffered.
- **Address decode:** only addresses in [`addr`, `addr` + 0x10 + 4·`channels`) are acknowledged. Any other address is neither acknowledged nor driven, which keeps the block overlay-compatible.
- **Write strobes:** byte write enables are honoured.
- **Prescaler:** an 8-bit down-counter produces a `tick` every `PRESCALE`+1 clocks while `EN`=1. `COUNT` advances only on `tick`.
- **Edge mode** (`CENTER`=0): `COUNT` runs 0 → `PERIOD`, then wraps to 0. The boundary is the tick on which `COUNT`=`PERIOD`.
- **Center mode** (`CENTER`=1): `COUNT` runs up 0 → `PERIOD`, then down to 0, and so on. The direction flips at `PERIOD` and at 0. The boundary is the tick on which `COUNT`=0 while counting down.
  - With `PERIOD`=0, `COUNT` stays at 0 and every tick is a boundary.
- **Output compare:** `pwm_out[i]` = (`COUNT` < `active_duty[i]`).
  - Duty 0 gives constant low.
  - Duty > `PERIOD` gives constant high.
  - Compare is unsigned, `width` bits.
- **Buffering:** bus writes update only the buffers. `active_period` and `active_duty[*]` load from the buffers on each boundary tick, and on every clock while `EN`=0.
- **Enable and disable:**
  - `EN`=0 holds `COUNT`=0, direction=up, and the prescaler at `PRESCALE`, and forces `pwm_out`=0.
  - Setting `EN` starts counting from 0 with the buffered values already active.
- **WRAP:** set on every boundary tick.
  - If a boundary tick and a W1C write land in the same cycle, set wins.
  - Changing `CENTER` while `EN`=1 takes effect at the next boundary.
- **Reset values:** on `rst_n` low, all registers, counters and buffers go to 0, direction is up, and `pwm_out`, `irq` and bus read data are 0. Reset asserted mid-period aborts immediately; there is no completion of the current cycle.

## Timing
- **Bus:** zero wait states. Writes commit at the clock edge of the accepted request. Read data is returned with the bus's standard one-cycle latency and reflects register state at the request edge.
- **Outputs:** `pwm_out` and `irq` lag the internal `COUNT`/`WRAP` by one clock.
- **Write to effect:** a `DUTY` write with `EN`=0 reaches `pwm_out` no earlier than 2 clocks after the write edge. With `EN`=1 it takes effect one clock after the next boundary tick.
- **Prescaler:** `PRESCALE`=0 gives one tick per clock, so the edge-mode frame is `PERIOD`+1 clocks. The center-mode frame is 2·`PERIOD` ticks.

## Configuration
- `BOA_PWM_CENTER_EN` defined: center-aligned mode is available as described above.
- `BOA_PWM_CENTER_EN` undefined:
  - `CTRL.CENTER` is read-only 0 and writes to it are ignored.
  - The direction flip-flop and down-count logic are removed; only edge mode exists.

## Test plan
- **Edge mode, basic:** reset; write `PERIOD`=9, `DUTY[0]`=3, `CTRL`=0x01 → `pwm_out[0]` high 3 clocks, low 7, repeating every 10 clocks; `COUNT` reads cycle 0..9.
- **Buffered reload:** while running with `PERIOD`=9, `DUTY[1]`=2, write `DUTY[1]`=8 mid-frame → current frame still shows 2 high clocks; the next frame shows 8. Also, `DUTY`=0 gives constant low and `DUTY`=10 gives constant high.
- **Prescaler and interrupt:** `PRESCALE`=3, `PERIOD`=4, `IRQ_EN`=1 → `COUNT` advances every 4 clocks. `irq` rises one clock after the first boundary (clock 20). A W1C on `STATUS` drops `irq`. A W1C coinciding with a boundary leaves `WRAP`=1.
- **Center mode** (macro defined): `PERIOD`=4, `DUTY[0]`=2 → `COUNT` sequence 0,1,2,3,4,3,2,1,0,1…; `pwm_out[0]` is high exactly while `COUNT` < 2. With the macro undefined, writing `CTRL`=0x03 reads back 0x01 and edge behaviour is kept.
- **Decode and reset:** access `addr`+0x10+4·`channels` → not acknowledged. Assert `rst_n` low mid-frame → `pwm_out`, `irq` and all registers read 0 immediately, and counting stays stopped after release until `EN` is set.
